// File: rtl/simt_reconv_stack_if.sv
// Purpose: entry type and execute-stage divergence interface for the SIMT reconvergence stack.
// Latency: n/a (type and wire bundle only).
// Backpressure: none; requests are single-cycle strobes.
// Ports (master = execute stage, slave = stack):
//   warp_id/current_pc select the warp and PC being examined;
//   stack_push/stack_pop/stack_push_entry modify the selected warp's stack;
//   clear/clear_warp_id reset one warp's stack and its error flags;
//   stack_top_entry/stack_at_reconvergence/stack_empty/stack_full/stack_depth report on warp_id;
//   overflow_err/underflow_err are sticky per-warp error flags.

package simt_reconv_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int WARP_SIZE  = 32;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] reconvergence_pc;
    logic [WARP_SIZE-1:0]  active_mask;
    logic [WARP_SIZE-1:0]  taken_mask;
  } simt_stack_entry_t;
endpackage

interface simt_reconv_stack_if #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 8,
  parameter int WID_W     = $clog2(NUM_WARPS),
  parameter int PTR_W     = $clog2(DEPTH) + 1
);
  logic [WID_W-1:0]                        warp_id;
  logic [simt_reconv_pkg::ADDR_WIDTH-1:0]  current_pc;
  logic                                    stack_push;
  logic                                    stack_pop;
  simt_reconv_pkg::simt_stack_entry_t      stack_push_entry;
  simt_reconv_pkg::simt_stack_entry_t      stack_top_entry;
  logic                                    stack_at_reconvergence;
  logic                                    stack_empty;
  logic                                    stack_full;
  logic [PTR_W-1:0]                        stack_depth;
  logic                                    clear;
  logic [WID_W-1:0]                        clear_warp_id;
  logic [NUM_WARPS-1:0]                    overflow_err;
  logic [NUM_WARPS-1:0]                    underflow_err;

  modport master (
    output warp_id, current_pc, stack_push, stack_pop, stack_push_entry, clear, clear_warp_id,
    input  stack_top_entry, stack_at_reconvergence, stack_empty, stack_full, stack_depth,
           overflow_err, underflow_err
  );

  modport slave (
    input  warp_id, current_pc, stack_push, stack_pop, stack_push_entry, clear, clear_warp_id,
    output stack_top_entry, stack_at_reconvergence, stack_empty, stack_full, stack_depth,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/simt_reconv_stack.sv
// Purpose: NUM_WARPS independent register-based LIFO reconvergence stacks, read/written for warp_id.
// Latency: push/pop/clear visible on read outputs 1 cycle after the request edge; warp_id/current_pc changes are combinational.
// Backpressure: none; always accepts, illegal push/pop only set sticky overflow/underflow flags.
// Ports: clk, rst_n (async active-low), bus (simt_reconv_stack_if.slave, see interface file).

module simt_reconv_stack #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 8,
  parameter int WID_W     = $clog2(NUM_WARPS),
  parameter int PTR_W     = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  simt_reconv_stack_if.slave  bus
);
  import simt_reconv_pkg::*;

  localparam int               IDX_W    = PTR_W - 1;
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);

  // Entry storage is deliberately not reset; sp alone defines validity.
  simt_stack_entry_t    entries [NUM_WARPS][DEPTH];
  logic [PTR_W-1:0]     sp      [NUM_WARPS];
  logic [NUM_WARPS-1:0] ovf_q;
  logic [NUM_WARPS-1:0] unf_q;

  logic [PTR_W-1:0]  cur_sp;
  logic              cur_empty;
  logic              cur_full;
  logic [IDX_W-1:0]  top_idx;
  simt_stack_entry_t top_raw;
  logic              clr_same;

  assign cur_sp    = sp[bus.warp_id];
  assign cur_empty = (cur_sp == '0);
  assign cur_full  = (cur_sp == FULL_CNT);
  // Wraps to DEPTH-1 when empty; the read outputs mask that case.
  assign top_idx   = IDX_W'(cur_sp - ONE);
  assign top_raw   = entries[bus.warp_id][top_idx];
  assign clr_same  = bus.clear && (bus.clear_warp_id == bus.warp_id);

  assign bus.stack_top_entry        = cur_empty ? '0 : top_raw;
  assign bus.stack_at_reconvergence = !cur_empty && (bus.current_pc == top_raw.reconvergence_pc);
  assign bus.stack_empty            = cur_empty;
  assign bus.stack_full             = cur_full;
  assign bus.stack_depth            = cur_sp;
  assign bus.overflow_err           = ovf_q;
  assign bus.underflow_err          = unf_q;

  logic             sp_we;
  logic [PTR_W-1:0] sp_nxt;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             set_ovf;
  logic             set_unf;

  always_comb begin
    sp_we   = 1'b0;
    sp_nxt  = cur_sp;
    wr_en   = 1'b0;
    wr_idx  = top_idx;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    // A clear of the same warp wins over that warp's push/pop.
    if (!clr_same) begin
      if (bus.stack_push && bus.stack_pop) begin
        // Replace top in place; on an empty stack this degenerates to a plain push.
        wr_en = 1'b1;
        if (cur_empty) begin
          wr_idx = '0;
          sp_we  = 1'b1;
          sp_nxt = ONE;
        end
      end else if (bus.stack_push) begin
        if (cur_full) begin
          set_ovf = 1'b1;
        end else begin
          wr_en  = 1'b1;
          wr_idx = cur_sp[IDX_W-1:0];
          sp_we  = 1'b1;
          sp_nxt = cur_sp + ONE;
        end
      end else if (bus.stack_pop) begin
        if (cur_empty) begin
          set_unf = 1'b1;
        end else begin
          sp_we  = 1'b1;
          sp_nxt = cur_sp - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) sp[w] <= '0;
      ovf_q <= '0;
      unf_q <= '0;
    end else begin
      if (sp_we)   sp[bus.warp_id]    <= sp_nxt;
      if (set_ovf) ovf_q[bus.warp_id] <= 1'b1;
      if (set_unf) unf_q[bus.warp_id] <= 1'b1;
      // Clear of another warp proceeds alongside this warp's update.
      if (bus.clear) begin
        sp[bus.clear_warp_id]    <= '0;
        ovf_q[bus.clear_warp_id] <= 1'b0;
        unf_q[bus.clear_warp_id] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) entries[bus.warp_id][wr_idx] <= bus.stack_push_entry;
  end

endmodule

// File: tb/tb_simt_reconv_stack.sv
module tb_simt_reconv_stack;
  import simt_reconv_pkg::*;

  localparam int NW = 4;
  localparam int DP = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  simt_reconv_stack_if #(.NUM_WARPS(NW), .DEPTH(DP)) bus ();

  simt_reconv_stack #(.NUM_WARPS(NW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one queue per warp, back of queue is top of stack.
  simt_stack_entry_t mq [NW][$];
  logic [NW-1:0]     m_ovf;
  logic [NW-1:0]     m_unf;

  function automatic simt_stack_entry_t mk(input logic [31:0] pc, input logic [31:0] am,
                                           input logic [31:0] tm);
    simt_stack_entry_t e;
    e.reconvergence_pc = pc;
    e.active_mask      = am;
    e.taken_mask       = tm;
    return e;
  endfunction

  function automatic simt_stack_entry_t m_top(input int w);
    if (mq[w].size() == 0) return '0;
    return mq[w][mq[w].size()-1];
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NW; w++) mq[w].delete();
    m_ovf = '0;
    m_unf = '0;
  endtask

  task automatic model_apply(input int w, input logic push, input logic pop,
                             input simt_stack_entry_t e, input logic clr, input int cw);
    if (!(clr && cw == w)) begin
      if (push && pop) begin
        if (mq[w].size() != 0) mq[w][mq[w].size()-1] = e;
        else mq[w].push_back(e);
      end else if (push) begin
        if (mq[w].size() < DP) mq[w].push_back(e);
        else m_ovf[w] = 1'b1;
      end else if (pop) begin
        if (mq[w].size() > 0) void'(mq[w].pop_back());
        else m_unf[w] = 1'b1;
      end
    end
    if (clr) begin
      mq[cw].delete();
      m_ovf[cw] = 1'b0;
      m_unf[cw] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int w;
    simt_stack_entry_t t;
    w = int'(bus.warp_id);
    t = m_top(w);
    chk({tag, ".depth"}, 128'(bus.stack_depth), 128'(mq[w].size()));
    chk({tag, ".empty"}, 128'(bus.stack_empty), 128'(mq[w].size() == 0));
    chk({tag, ".full"},  128'(bus.stack_full),  128'(mq[w].size() == DP));
    chk({tag, ".top"},   128'(bus.stack_top_entry), 128'(t));
    chk({tag, ".recon"}, 128'(bus.stack_at_reconvergence),
        128'((mq[w].size() != 0) && (bus.current_pc == t.reconvergence_pc)));
    chk({tag, ".ovf"},   128'(bus.overflow_err),  128'(m_ovf));
    chk({tag, ".unf"},   128'(bus.underflow_err), 128'(m_unf));
  endtask

  task automatic step(input int w, input logic push, input logic pop,
                      input simt_stack_entry_t e, input logic clr, input int cw);
    bus.warp_id          = 2'(w);
    bus.stack_push       = push;
    bus.stack_pop        = pop;
    bus.stack_push_entry = e;
    bus.clear            = clr;
    bus.clear_warp_id    = 2'(cw);
    @(posedge clk);
    model_apply(w, push, pop, e, clr, cw);
    #1;
    bus.stack_push = 1'b0;
    bus.stack_pop  = 1'b0;
    bus.clear      = 1'b0;
  endtask

  task automatic peek(input int w, input string tag);
    bus.warp_id = 2'(w);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic pu, po, cl;
    int   w, op, cw;

    rst_n                = 1'b0;
    bus.warp_id          = '0;
    bus.current_pc       = '0;
    bus.stack_push       = 1'b0;
    bus.stack_pop        = 1'b0;
    bus.stack_push_entry = '0;
    bus.clear            = 1'b0;
    bus.clear_warp_id    = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.top_zero", 128'(bus.stack_top_entry), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset");

    // Warp 1: single push, reconvergence compare.
    bus.current_pc = 32'h100;
    step(1, 1'b1, 1'b0, mk(32'h100, 32'hFFFF_FFFF, 32'h0000_FFFF), 1'b0, 0);
    check_all("w1_push");
    chk("w1_depth_is_1", 128'(bus.stack_depth), 128'(1));
    chk("w1_recon_hit", 128'(bus.stack_at_reconvergence), 128'(1));
    chk("w1_taken", 128'(bus.stack_top_entry.taken_mask), 128'(32'h0000_FFFF));
    bus.current_pc = 32'h104;
    #1;
    check_all("w1_pc104");
    chk("w1_recon_miss", 128'(bus.stack_at_reconvergence), 128'(0));

    // Warp 2: fill, then overflow.
    for (int i = 1; i <= DP; i++) begin
      step(2, 1'b1, 1'b0, mk(32'(i * 16), 32'(i), 32'(~i)), 1'b0, 0);
      check_all("w2_fill");
    end
    chk("w2_full", 128'(bus.stack_full), 128'(1));
    step(2, 1'b1, 1'b0, mk(32'h90, 32'h9, 32'h9), 1'b0, 0);
    check_all("w2_ovf");
    chk("w2_ovf_depth", 128'(bus.stack_depth), 128'(8));
    chk("w2_ovf_top_pc", 128'(bus.stack_top_entry.reconvergence_pc), 128'(32'h80));
    chk("w2_ovf_flag", 128'(bus.overflow_err), 128'(4'b0100));
    peek(0, "w0_peek");
    peek(1, "w1_peek");
    peek(3, "w3_peek");

    // Warp 3: underflow, then push+pop on empty and non-empty stacks.
    step(3, 1'b0, 1'b1, '0, 1'b0, 0);
    check_all("w3_unf");
    chk("w3_unf_flag", 128'(bus.underflow_err), 128'(4'b1000));
    step(3, 1'b1, 1'b1, mk(32'h180, 32'h1, 32'h1), 1'b0, 0);
    check_all("w3_pp_empty");
    chk("w3_pp_empty_depth", 128'(bus.stack_depth), 128'(1));
    step(3, 1'b1, 1'b1, mk(32'h200, 32'h2, 32'h2), 1'b0, 0);
    check_all("w3_pp_replace");
    chk("w3_pp_top_pc", 128'(bus.stack_top_entry.reconvergence_pc), 128'(32'h200));
    chk("w3_pp_depth", 128'(bus.stack_depth), 128'(1));

    // Clear of the same warp overrides its push.
    step(1, 1'b1, 1'b0, mk(32'h300, 32'h3, 32'h3), 1'b1, 1);
    check_all("w1_clear_same");
    chk("w1_clear_depth", 128'(bus.stack_depth), 128'(0));

    // Clear of another warp alongside a push.
    step(0, 1'b1, 1'b0, mk(32'h400, 32'h4, 32'h4), 1'b1, 2);
    check_all("w0_push_w2_clear");
    chk("w0_depth_inc", 128'(bus.stack_depth), 128'(1));
    peek(2, "w2_cleared");
    chk("w2_clear_ovf", 128'(bus.overflow_err[2]), 128'(0));
    chk("w2_clear_depth", 128'(bus.stack_depth), 128'(0));

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      w  = $urandom_range(0, NW - 1);
      op = $urandom_range(0, 99);
      pu = (op < 45) || (op >= 80 && op < 90);
      po = (op >= 45 && op < 90);
      cl = ($urandom_range(0, 19) == 0);
      cw = $urandom_range(0, NW - 1);
      bus.current_pc = 32'($urandom_range(0, 7) * 4);
      step(w, pu, po, mk(32'($urandom_range(0, 7) * 4), $urandom, $urandom), cl, cw);
      check_all("rand");
      if ($urandom_range(0, 3) == 0) peek($urandom_range(0, NW - 1), "rand_peek");
    end

    // Reset asserted mid-operation discards all stacks at once.
    step(0, 1'b1, 1'b0, mk(32'h500, 32'h5, 32'h5), 1'b0, 0);
    check_all("pre_midreset");
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NW; i++) peek(i, "midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("after_midreset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/simt_reconv_stack.md
# simt_reconv_stack

Per-warp SIMT reconvergence stack. It is the storage and responder side of the execute stage's divergence interface. It accepts push and pop requests for the warp currently in execute and presents that warp's top-of-stack entry. It also flags when the warp's current PC has reached the top entry's reconvergence PC. It holds NUM_WARPS independent LIFO stacks in registers, with per-warp pointers and error flags.

## Interface
Parameters:
- NUM_WARPS, default 4: number of independent warp stacks.
- DEPTH, default 8: entries per warp stack; a power of two, at least 2.
- WID_W, default $clog2(NUM_WARPS): warp index width.
- PTR_W, default $clog2(DEPTH)+1: occupancy counter width.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- warp_id  in  WID_W  warp currently in execute; selects the stack for push, pop and all read outputs
- current_pc  in  ADDR_WIDTH  PC of the instruction in execute for warp_id
- stack_push  in  1  push stack_push_entry onto stack[warp_id]
- stack_pop  in  1  pop stack[warp_id]
- stack_push_entry  in  simt_stack_entry_t  entry to push; fields reconvergence_pc, active_mask, taken_mask
- stack_top_entry  out  simt_stack_entry_t  top entry of stack[warp_id]; '0 when that stack is empty
- stack_at_reconvergence  out  1  stack[warp_id] non-empty and current_pc == top.reconvergence_pc
- stack_empty  out  1  stack[warp_id] occupancy == 0
- stack_full  out  1  stack[warp_id] occupancy == DEPTH
- stack_depth  out  PTR_W  occupancy of stack[warp_id]
- clear  in  1  reset stack[clear_warp_id] (warp launch or exit)
- clear_warp_id  in  WID_W  warp to clear
- overflow_err  out  NUM_WARPS  sticky per-warp flag: push was attempted while full
- underflow_err  out  NUM_WARPS  sticky per-warp flag: pop was attempted while empty

## Operation
- Storage: entries[NUM_WARPS][DEPTH] of simt_stack_entry_t, plus a per-warp occupancy counter sp[w] of width PTR_W. The top is entries[w][sp[w]-1].
- Read path is combinational from registered state, selected by warp_id: stack_top_entry, stack_empty, stack_full, stack_depth, stack_at_reconvergence.
- Push only, not full: entries[w][sp] <= entry; sp <= sp+1.
- Push only, full: entry is dropped, sp is unchanged, overflow_err[w] <= 1.
- Pop only, non-empty: sp <= sp-1. Entry contents are not cleared.
- Pop only, empty: no change, underflow_err[w] <= 1.
- Push and pop in the same cycle:
  - Non-empty: replace the top in place, entries[w][sp-1] <= entry, sp unchanged, no error.
  - Empty: behaves as push only, sp becomes 1, underflow_err is not set.
- Clear: sp[clear_warp_id] <= 0, and both error flags for that warp are cleared.
  - When clear_warp_id == warp_id, clear overrides any push or pop that cycle.
  - When the warps differ, both actions take effect.
- Error flags are sticky until clear of that warp or reset.
- Reconvergence compare is an exact ADDR_WIDTH equality against the top entry. It is forced to 0 when the stack is empty.

## Timing
- Reset (async assert, sync release): all sp = 0, overflow_err = 0, underflow_err = 0. Entry storage is not reset.
- Outputs immediately after reset: stack_empty=1, stack_full=0, stack_depth=0, stack_top_entry='0, stack_at_reconvergence=0.
- A push, pop or clear is visible on the read outputs in the cycle after the request edge. Latency is 1 cycle; there is no same-cycle bypass.
- Requests are single-cycle strobes with no handshake. The stack always accepts; illegal requests are flagged, not back-pressured.
- A change of warp_id or current_pc alone updates the outputs combinationally in the same cycle.
- Reset asserted mid-operation discards all stacks immediately.

## Test plan
- Reset, then warp_id=0 → empty=1, full=0, depth=0, top='0, at_reconvergence=0, err flags all 0.
- Warp 1:
  - Push {pc=0x100, mask=0xFFFF_FFFF, taken=0x0000_FFFF}, then set current_pc=0x100 → next cycle depth=1, top matches the pushed entry, at_reconvergence=1.
  - Set current_pc=0x104 → at_reconvergence=0.
- Warp 2: push 8 entries with pc=0x10..0x80 → full=1. A 9th push (pc=0x90) → depth stays 8, top.pc=0x80, overflow_err[2]=1. Warps 0, 1 and 3 are unaffected.
- Warp 3:
  - Pop while empty → underflow_err[3]=1, depth=0.
  - Then push and pop in the same cycle → depth=1, no further error.
  - Then push and pop again with pc=0x200 → depth=1, top.pc=0x200.
- Warp 1 at depth=1, clear with clear_warp_id=1 while pushing warp_id=1 → depth=0, top='0, error flags for warp 1 = 0.
- Warp 2 full with overflow set; clear warp 2 while pushing warp 0 → warp 2 depth=0 and overflow_err[2]=0; warp 0 depth increments by 1.
